// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths on the 50 MHz clock.
package uart_pkg;
  localparam int CLKS_PER_BIT_9600 = 5208;
  localparam int UART_DATA_BITS    = 8;
  localparam int UART_TIMER_W      = 13;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus a falling-edge detector.
module uart_rx_sync (
  input  logic clk_50M,
  input  logic reset_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);
  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle line is high, so all flops reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign fall = prev_q & ~sync_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, mid-bit sampling, parity and stop checks, one-cycle valid strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                      clk_50M,
  input  logic                      reset_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      parity_err,
  output logic                      frame_err,
  output logic                      busy
);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [UART_TIMER_W-1:0] HALF_M1  = UART_TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [UART_TIMER_W-1:0] BIT_M1   = UART_TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk_50M (clk_50M),
    .reset_n (reset_n),
    .rx      (rx),
    .rx_s    (rx_s),
    .fall    (fall)
  );

  uart_rx_state_t            state_q;
  logic [UART_TIMER_W-1:0]   timer_q;
  logic [IDX_W-1:0]          bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      par_bit_q;
  logic [UART_DATA_BITS-1:0] rx_data_q;
  logic                      rx_valid_q;
  logic                      parity_err_q;
  logic                      frame_err_q;

  logic bit_tick;
  logic parity_err_d;

  assign bit_tick = (timer_q == BIT_M1);

  // Even parity: any odd count of ones across data+parity is an error; odd parity inverts that.
  assign parity_err_d = (PARITY_EN != 0) ?
                        ((^shift_q) ^ par_bit_q ^ (PARITY_ODD != 0)) : 1'b0;

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall) begin
            timer_q <= '0;
            state_q <= START;
          end
        end
        START: begin
          // A line back high at mid-start is a glitch, not a frame.
          if (timer_q == HALF_M1) begin
            if (!rx_s) begin
              timer_q   <= '0;
              bit_idx_q <= '0;
              state_q   <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            timer_q <= timer_q + UART_TIMER_W'(1);
          end
        end
        DATA: begin
          if (bit_tick) begin
            shift_q[bit_idx_q] <= rx_s;
            timer_q            <= '0;
            bit_idx_q          <= bit_idx_q + IDX_W'(1);
            if (bit_idx_q == LAST_IDX) begin
              state_q <= (PARITY_EN != 0) ? PARITY : STOP;
            end
          end else begin
            timer_q <= timer_q + UART_TIMER_W'(1);
          end
        end
        PARITY: begin
          if (bit_tick) begin
            par_bit_q <= rx_s;
            timer_q   <= '0;
            state_q   <= STOP;
          end else begin
            timer_q <= timer_q + UART_TIMER_W'(1);
          end
        end
        STOP: begin
          // Re-arming at mid-stop lets a directly following start bit be caught.
          if (bit_tick) begin
            rx_data_q    <= shift_q;
            parity_err_q <= parity_err_d;
            frame_err_q  <= ~rx_s;
            rx_valid_q   <= 1'b1;
            timer_q      <= '0;
            state_q      <= IDLE;
          end else begin
            timer_q <= timer_q + UART_TIMER_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx at a shortened bit period.
module tb_uart_rx;
  localparam int CPB  = 48;
  localparam int HALF = CPB / 2;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } frame_t;

  logic       clk_50M = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx      = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  frame_t got_q[$];
  frame_t exp_q[$];

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .PARITY_EN    (1),
    .PARITY_ODD   (0)
  ) dut (
    .clk_50M    (clk_50M),
    .reset_n    (reset_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #10 clk_50M = ~clk_50M;

  always @(negedge clk_50M) begin
    if (rx_valid) got_q.push_back('{d: rx_data, pe: parity_err, fe: frame_err});
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk_50M);
    #1;
  endtask

  // Reference: even parity error iff ones(data)+parity is odd; frame error iff stop is low.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    frame_t e;
    e.d  = d;
    e.pe = ((($countones(d) + int'(par)) % 2) == 1);
    e.fe = ~stp;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stp);
  endtask

  task automatic clear_queues();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (4) @(posedge clk_50M);
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got=%b want=0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    reset_n = 1'b1;
    repeat (CPB) @(posedge clk_50M);
    #1;
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL reset_no_valid got=%0d want=0", got_q.size()); end
  endtask

  task automatic test_even_ok();
    clear_queues();
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (CPB) @(posedge clk_50M);
    #1;
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL even_ok_count got=%0d want=1", got_q.size());
    end else begin
      checks++; if (got_q[0] !== frame_t'({8'hA5, 1'b0, 1'b0})) begin
        errors++; $display("FAIL even_ok_frame got=%h/%b/%b want=a5/0/0", got_q[0].d, got_q[0].pe, got_q[0].fe);
      end
    end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL even_ok_held got=%h want=a5", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL even_ok_busy got=%b want=0", busy); end
  endtask

  task automatic test_parity_err();
    clear_queues();
    send_frame(8'h01, 1'b0, 1'b1);
    repeat (8) @(posedge clk_50M);
    #1;
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL parity_err_count got=%0d want=1", got_q.size());
    end else begin
      checks++; if (got_q[0] !== frame_t'({8'h01, 1'b1, 1'b0})) begin
        errors++; $display("FAIL parity_err_frame got=%h/%b/%b want=01/1/0", got_q[0].d, got_q[0].pe, got_q[0].fe);
      end
    end
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_err_held got=%b want=1", parity_err); end
  endtask

  task automatic test_frame_err();
    clear_queues();
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (3 * CPB) @(posedge clk_50M);
    #1;
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL frame_err_count got=%0d want=1", got_q.size());
    end else begin
      checks++; if (got_q[0] !== frame_t'({8'h3C, 1'b0, 1'b1})) begin
        errors++; $display("FAIL frame_err_frame got=%h/%b/%b want=3c/0/1", got_q[0].d, got_q[0].pe, got_q[0].fe);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_err_low_busy got=%b want=0", busy); end
    drive_bit(1'b1);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL frame_err_no_retrig got=%0d want=1", got_q.size()); end
    send_frame(8'h7E, 1'b0, 1'b1);
    repeat (4) @(posedge clk_50M);
    #1;
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL frame_err_rearm_count got=%0d want=2", got_q.size());
    end else begin
      checks++; if (got_q[1] !== exp_q[1]) begin
        errors++; $display("FAIL frame_err_rearm got=%h/%b/%b want=%h/%b/%b", got_q[1].d, got_q[1].pe, got_q[1].fe, exp_q[1].d, exp_q[1].pe, exp_q[1].fe);
      end
    end
  endtask

  task automatic test_glitch();
    clear_queues();
    repeat (CPB) @(posedge clk_50M);
    #1;
    rx = 1'b0;
    repeat (HALF / 2) @(posedge clk_50M);
    #1;
    rx = 1'b1;
    repeat (8 - HALF / 2) @(posedge clk_50M);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise got=%b want=1", busy); end
    repeat (HALF) @(posedge clk_50M);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall got=%b want=0", busy); end
    repeat (2 * CPB) @(posedge clk_50M);
    #1;
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_no_valid got=%0d want=0", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    repeat (8) @(posedge clk_50M);
    #1;
    checks++;
    if (got_q.size() != 3) begin
      errors++; $display("FAIL b2b_count got=%0d want=3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL b2b_frame%0d got=%h/%b/%b want=%h/%b/%b", i, got_q[i].d, got_q[i].pe, got_q[i].fe, exp_q[i].d, exp_q[i].pe, exp_q[i].fe);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       par;
    logic       stp;
    clear_queues();
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom);
      par = (^d) ^ ($urandom_range(3) == 0);
      stp = ($urandom_range(4) != 0);
      send_frame(d, par, stp);
      if (!stp) drive_bit(1'b1);
      repeat ($urandom_range(2)) drive_bit(1'b1);
    end
    repeat (8) @(posedge clk_50M);
    #1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++; if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL random_frame%0d got=%h/%b/%b want=%h/%b/%b", i, got_q[i].d, got_q[i].pe, got_q[i].fe, exp_q[i].d, exp_q[i].pe, exp_q[i].fe);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    clear_queues();
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (HALF) @(posedge clk_50M);
    #1;
    reset_n = 1'b0;
    rx      = 1'b1;
    #2;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data got=%h want=00", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    checks++; if ({parity_err, frame_err} !== 2'b00) begin errors++; $display("FAIL rstmid_flags got=%b want=00", {parity_err, frame_err}); end
    repeat (3) @(posedge clk_50M);
    #1;
    reset_n = 1'b1;
    repeat (2 * CPB) @(posedge clk_50M);
    #1;
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rstmid_no_valid got=%0d want=0", got_q.size()); end
    clear_queues();
    send_frame(8'h81, 1'b0, 1'b1);
    repeat (4) @(posedge clk_50M);
    #1;
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL rstmid_next_count got=%0d want=1", got_q.size());
    end else begin
      checks++; if (got_q[0] !== frame_t'({8'h81, 1'b0, 1'b0})) begin
        errors++; $display("FAIL rstmid_next_frame got=%h/%b/%b want=81/0/0", got_q[0].d, got_q[0].pe, got_q[0].fe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_even_ok();
    test_parity_err();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the 50 MHz UART path. It is the receive-side counterpart of the transmit timing generator and transmitter. It synchronises the `rx` line, detects a start bit, samples each bit at mid-bit, and checks parity and stop. Each frame is delivered as a byte with a one-cycle valid strobe and per-frame error flags. Default frame is 11 bits: start, 8 data LSB first, even parity, stop, at 9600 baud.

## Interface
- `CLKS_PER_BIT`, default 5208: clk_50M cycles per bit period (50 MHz / 9600).
- `PARITY_EN`, default 1: 1 means a parity bit follows the data; 0 means no parity bit (10-bit frame).
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.
- `clk_50M`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line, idle high, asynchronous to `clk_50M`.
- `rx_data`  out  8  last received byte. Held until the next frame completes.
- `rx_valid`  out  1  one-cycle pulse when a frame completes.
- `parity_err`  out  1  parity mismatch for the frame flagged by `rx_valid`. Held with `rx_data`.
- `frame_err`  out  1  stop bit sampled low for the frame flagged by `rx_valid`. Held with `rx_data`.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- Input conditioning:
  - `rx` passes through a 2-flop synchroniser; both flops reset to 1.
  - A third flop holds the previous synchronised value for edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a falling edge of the synchronised rx (previous 1, current 0), clear the bit timer and go to START.
  - START: when the timer reaches HALF-1 (HALF = `CLKS_PER_BIT`/2, integer division), sample the line.
    - Sample 0: clear the timer and the bit index, then go to DATA.
    - Sample 1: treat as a glitch and return to IDLE with no output.
  - DATA: when the timer reaches `CLKS_PER_BIT`-1, sample the line into `shift[bit_idx]` (LSB first) and clear the timer.
    - After bit_idx 7, go to PARITY if `PARITY_EN`, else to STOP.
  - PARITY: at `CLKS_PER_BIT`-1, sample the parity bit and go to STOP.
  - STOP: at `CLKS_PER_BIT`-1, sample the stop bit, then:
    - load `rx_data` from `shift`;
    - set `parity_err` (0 if `PARITY_EN`=0) and `frame_err`;
    - pulse `rx_valid`;
    - return to IDLE.
- Parity check:
  - Even parity: error when XOR of the 8 data bits and the parity bit is 1.
  - Odd parity: error when that XOR is 0.
- Bit timer: 13 bits wide (enough for 5208). It never wraps inside a bit: it is cleared at every sample point.
- No backpressure. A new frame overwrites `rx_data` regardless of whether it was consumed.
- Framing error: after a frame with `frame_err`, the receiver re-arms in IDLE and needs a fresh 1→0 edge. A line held low does not retrigger.

## Timing
- Reset values:
  - `rx_data`=0x00, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
  - FSM in IDLE, timer=0, bit_idx=0, synchroniser flops=1.
- Synchroniser latency is 2 cycles from the `rx` pin to edge detection.
- Start-detect sample lands HALF cycles after the detected edge. Each later sample is `CLKS_PER_BIT` cycles after the previous one.
- `rx_valid`, `rx_data` and the flags update on the same clock edge as the stop-bit sample.
  - Latency from the stop-bit mid-point to `rx_valid` is 1 cycle, plus the 2 synchroniser cycles.
- `busy` rises the cycle after edge detection and falls with `rx_valid` (or on glitch rejection).
- IDLE is re-entered at mid-stop, so a start bit directly following the stop bit (back-to-back frames) is received.
- `reset_n` asserted mid-frame: all state returns to reset values immediately. The partial frame is discarded with no `rx_valid`.

## Structure
- Shared package `uart_pkg`:
  - `CLKS_PER_BIT_9600` = 5208;
  - FSM state enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - constant `UART_DATA_BITS` = 8.
  - The transmitter reuses `CLKS_PER_BIT_9600` and `UART_DATA_BITS`.
- One natural sub-module, `uart_rx_sync`: 2-flop synchroniser plus falling-edge detector.
  - Outputs: `rx_s` and `fall`.
  - Reset value of all its flops is 1.

## Test plan
- Even parity, 9600 baud: send 0xA5 with parity bit 0 and stop 1 → one `rx_valid` pulse, `rx_data`=0xA5, `parity_err`=0, `frame_err`=0.
- Send 0x01 with parity bit 0 (wrong for even parity) → `rx_data`=0x01, `parity_err`=1, `frame_err`=0.
- Send 0x3C with stop bit 0 → `rx_valid` pulse, `rx_data`=0x3C, `frame_err`=1. No second frame while the line stays low until it returns high and falls again.
- Drive a 1000-cycle low glitch on idle `rx` → no `rx_valid`; `busy` returns to 0 about 2604 cycles after the glitch start.
- Send frames 0x00, 0xFF, 0x5A back-to-back with no idle gap → three `rx_valid` pulses, data in order, all flags 0.
- Assert `reset_n` low during data bit 4 of a frame → outputs at reset values, no `rx_valid`; the next full frame, 0x81, is received correctly.
